// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl -- central pipeline controller for the 5-stage RV32I core.
//
// Produces the per-register stall vector, the branch-redirect flush pulse with
// its target PC, replays branches that EX resolved while it was frozen, and
// keeps saturating stall/flush counters plus a sticky stall-timeout flag.
//
// Parameters
//   TIMEOUT       consecutive stalled cycles before hang_err sets (>=2)
//   CNT_W         width of the saturating performance counters
//
// Ports
//   clk           clock, all state updates on posedge
//   rst           synchronous reset, active-high
//   stallreq_if   fetch waiting on instruction memory
//   stallreq_id   load-use hazard in decode
//   stallreq_ex   multi-cycle EX operation in progress
//   stallreq_mem  data memory busy
//   branch_flag   EX resolved a taken branch/jump this cycle
//   branch_target target PC accompanying branch_flag
//   stall[5:0]    [0]=pc [1]=if_id [2]=id_ex [3]=ex_mem [4]=mem_wb [5]=wb
//   flush         one-cycle pulse squashing if_id and id_ex
//   new_pc        redirect target, valid while flush=1
//   stall_cycles  saturating count of cycles with stall!=0
//   flush_count   saturating count of flush pulses
//   hang_err      sticky: stall held TIMEOUT consecutive cycles
// -----------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic             branch_flag,
    input  logic [31:0]      branch_target,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic             hang_err
);

    localparam int CONSEC_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic [5:0]           stall_raw;
    logic                 go_flush;
    logic                 pend_reg;
    logic [31:0]          pend_pc_reg;
    logic [31:0]          new_pc_reg;
    logic [CNT_W-1:0]     stall_cycles_reg;
    logic [CNT_W-1:0]     flush_count_reg;
    logic [CONSEC_W-1:0]  consec_reg;
    logic                 hang_reg;

    // Highest requesting stage wins; its register and everything upstream hold.
    always_comb begin
        stall_raw = 6'b000000;
        if (stallreq_mem)      stall_raw = 6'b011111;
        else if (stallreq_ex)  stall_raw = 6'b001111;
        else if (stallreq_id)  stall_raw = 6'b000111;
        else if (stallreq_if)  stall_raw = 6'b000011;
    end

    // A redirect is issued when the EX instruction advances (stall[3]=0) and
    // either a live branch or a replayed one is present. During the flush
    // cycle the EX instruction is being squashed, so its branch is ignored.
    assign go_flush = (state_reg != FLUSH) && !stall_raw[3] && (branch_flag || pend_reg);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_reg <= RUN;
        else     state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN, STALL: begin
                if (go_flush)                state_next = FLUSH;
                else if (stall_raw != 6'd0)  state_next = STALL;
                else                         state_next = RUN;
            end
            FLUSH: begin
                if (stall_raw != 6'd0)       state_next = STALL;
                else                         state_next = RUN;
            end
            default:                         state_next = RUN;
        endcase
    end

    // Output logic: flush overrides any stall request for its one cycle.
    always_comb begin
        flush = (state_reg == FLUSH);
        stall = (rst || flush) ? 6'b000000 : stall_raw;
    end

    // Pending branch, redirect target, counters and timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_reg         <= 1'b0;
            pend_pc_reg      <= '0;
            new_pc_reg       <= '0;
            stall_cycles_reg <= '0;
            flush_count_reg  <= '0;
            consec_reg       <= '0;
            hang_reg         <= 1'b0;
        end else begin
            // EX re-presents the same branch every stalled cycle; keep the first.
            if (branch_flag && stall[3] && !pend_reg) begin
                pend_reg    <= 1'b1;
                pend_pc_reg <= branch_target;
            end

            if (go_flush) begin
                new_pc_reg <= pend_reg ? pend_pc_reg : branch_target;
                pend_reg   <= 1'b0;
                if (flush_count_reg != '1)
                    flush_count_reg <= flush_count_reg + 1'b1;
            end

            if (stall != 6'd0) begin
                if (stall_cycles_reg != '1)
                    stall_cycles_reg <= stall_cycles_reg + 1'b1;
                if (consec_reg != CONSEC_W'(TIMEOUT))
                    consec_reg <= consec_reg + 1'b1;
                if (consec_reg >= CONSEC_W'(TIMEOUT - 1))
                    hang_reg <= 1'b1;
            end else begin
                consec_reg <= '0;
            end
        end
    end

    assign new_pc       = new_pc_reg;
    assign stall_cycles = stall_cycles_reg;
    assign flush_count  = flush_count_reg;
    assign hang_err     = hang_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl -- scoreboard bench for pipe_ctrl.
// The driver applies one cycle of inputs at each negedge, asks the reference
// model what the DUT outputs should be during that cycle, and queues it. The
// monitor samples the DUT shortly after each negedge and pops/compares.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

    localparam int TIMEOUT = 8;
    localparam int CW      = 5;
    localparam int MAXC    = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic          branch_flag;
    logic [31:0]   branch_target;
    logic [5:0]    stall;
    logic          flush;
    logic [31:0]   new_pc;
    logic [CW-1:0] stall_cycles;
    logic [CW-1:0] flush_count;
    logic          hang_err;

    pipe_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .branch_flag  (branch_flag),
        .branch_target(branch_target),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count),
        .hang_err     (hang_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] npc;
        int          sc;
        int          fc;
        logic        hang;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // ---------------- reference model state ----------------
    bit          m_pend     = 0;
    logic [31:0] m_pend_pc  = '0;
    bit          m_flushing = 0;
    logic [31:0] m_npc      = '0;
    int          m_sc       = 0;
    int          m_fc       = 0;
    int          m_run      = 0;
    bit          m_hang     = 0;

    // Deepest stage asking to stop: 1=if .. 4=mem, 0=none.
    function automatic int deepest(bit i, bit d, bit e, bit m);
        if (m) return 4;
        if (e) return 3;
        if (d) return 2;
        if (i) return 1;
        return 0;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req, int c);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL cycle %0d %s: got %h expected %h", c, name, act, req);
        end
    endtask

    // One bus cycle: drive inputs, queue the expected outputs, advance model.
    task automatic drive(bit r, bit i, bit d, bit e, bit m, bit bf, logic [31:0] tgt);
        exp_t ex;
        int   lvl;
        bit   take;
        @(negedge clk);
        rst = r; stallreq_if = i; stallreq_id = d; stallreq_ex = e; stallreq_mem = m;
        branch_flag = bf; branch_target = tgt;
        cyc++;

        // Stages 0..lvl stop; the flush cycle and reset stop nothing.
        lvl = (r || m_flushing) ? 0 : deepest(i, d, e, m);
        ex.cyc   = cyc;
        ex.stall = (lvl == 0) ? 6'd0 : 6'((1 << (lvl + 1)) - 1);
        ex.flush = m_flushing;
        ex.npc   = m_npc;
        ex.sc    = m_sc;
        ex.fc    = m_fc;
        ex.hang  = m_hang;
        exp_q.push_back(ex);

        if (r) begin
            m_pend = 0; m_pend_pc = '0; m_flushing = 0; m_npc = '0;
            m_sc = 0; m_fc = 0; m_run = 0; m_hang = 0;
        end else begin
            // EX (stage 3) moves on unless mem or ex stall is active.
            take = !m_flushing && (lvl < 3) && (bf || m_pend);
            if (!m_flushing && bf && lvl >= 3 && !m_pend) begin
                m_pend = 1; m_pend_pc = tgt;
            end
            if (take) begin
                m_npc  = m_pend ? m_pend_pc : tgt;
                m_pend = 0;
                if (m_fc < MAXC) m_fc++;
            end
            m_flushing = take;
            if (lvl > 0) begin
                if (m_sc < MAXC) m_sc++;
                m_run++;
                if (m_run >= TIMEOUT) m_hang = 1;
            end else begin
                m_run = 0;
            end
        end
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0, 32'h0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("stall",        {26'd0, stall},        {26'd0, e.stall}, e.cyc);
                check("flush",        {31'd0, flush},        {31'd0, e.flush}, e.cyc);
                if (e.flush)
                    check("new_pc",   new_pc,                e.npc,            e.cyc);
                check("stall_cycles", 32'(stall_cycles),     32'(e.sc),        e.cyc);
                check("flush_count",  32'(flush_count),      32'(e.fc),        e.cyc);
                check("hang_err",     {31'd0, hang_err},     {31'd0, e.hang},  e.cyc);
                $display("cyc %0d rst=%0b req=%0b%0b%0b%0b bf=%0b stall=%b flush=%0b new_pc=%h sc=%0d fc=%0d hang=%0b",
                         e.cyc, rst, stallreq_mem, stallreq_ex, stallreq_id, stallreq_if,
                         branch_flag, stall, flush, new_pc, stall_cycles, flush_count, hang_err);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1; stallreq_if = 0; stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
        branch_flag = 0; branch_target = '0;
        repeat (2) @(posedge clk);

        // 1: mem stall for three cycles
        idle(1);
        for (int k = 0; k < 3; k++) drive(0, 0, 0, 0, 1, 0, 32'h0);
        idle(2);
        // 2: id + ex together, ex wins
        drive(0, 0, 1, 1, 0, 0, 32'h0);
        idle(1);
        // 3: unstalled branch
        drive(0, 0, 0, 0, 0, 1, 32'h0000_0100);
        idle(2);
        // 4: branches during mem stall, first target replayed after release
        drive(0, 0, 0, 0, 1, 1, 32'h0000_0200);
        drive(0, 0, 0, 0, 1, 1, 32'h0000_0300);
        drive(0, 0, 0, 0, 1, 1, 32'h0000_0300);
        drive(0, 0, 0, 0, 1, 1, 32'h0000_0300);
        drive(0, 0, 0, 0, 0, 1, 32'h0000_0300);
        idle(2);
        // branch with only an if/id stall is accepted; branch during flush ignored
        drive(0, 0, 1, 0, 0, 1, 32'h0000_0400);
        drive(0, 1, 0, 0, 0, 1, 32'h0000_0500);
        idle(2);
        // 5: timeout
        for (int k = 0; k < TIMEOUT; k++) drive(0, 0, 0, 1, 0, 0, 32'h0);
        idle(2);
        drive(1, 0, 0, 0, 0, 0, 32'h0);
        idle(1);
        // 6: pending branch discarded by reset mid-stall
        drive(0, 0, 0, 1, 0, 1, 32'h0000_0600);
        drive(1, 0, 0, 1, 0, 0, 32'h0);
        idle(3);

        // Randomized traffic, including occasional resets
        for (int n = 0; n < 1500; n++) begin
            drive(($urandom_range(99) == 0),
                  ($urandom_range(3) == 0), ($urandom_range(4) == 0),
                  ($urandom_range(5) == 0), ($urandom_range(6) == 0),
                  ($urandom_range(2) == 0), {$urandom_range(32'hFFFF), 2'b00, 14'd0} ^ $urandom);
        end
        idle(3);

        @(negedge clk);
        #5;
        check("queue_drained", 32'(exp_q.size()), 32'd0, cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
